// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: immediate formats, opcodes and the ID/EX entry payload.
package rv32_pkg;

    localparam int unsigned XLEN_W  = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned IMMSRC_W = 3;

    typedef enum logic [IMMSRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic [XLEN_W-1:0] instr;
        logic [XLEN_W-1:0] pc;
        imm_src_t          imm_src;
        logic [XLEN_W-1:0] imm;
        logic              illegal;
    } id_entry_t;

endpackage

// File: rtl/id_skid_buffer.sv
// Output register plus one skid entry; in_ready is registered so it never depends on out_ready combinationally.
module id_skid_buffer
    import rv32_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  id_entry_t in_entry,
    input  logic      flush,
    output logic      out_valid,
    input  logic      out_ready,
    output id_entry_t out_entry
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } occ_state_t;

    occ_state_t state_q, state_d;
    id_entry_t  out_q, out_d;
    id_entry_t  skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept_c;
    logic       consume_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Flush wins over any accept/consume in the same cycle.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        skid_d    = skid_q;
        accept_c  = in_valid && in_ready_q;
        consume_c = (state_q != ST_EMPTY) && out_ready;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        out_d   = in_entry;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (accept_c && consume_c) begin
                        out_d = in_entry;
                    end else if (accept_c) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end else if (consume_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume_c) begin
                        out_d   = skid_q;
                        state_d = ST_HALF;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_entry = out_q;

endmodule

// File: rtl/immediate_generator.sv
// Combinational RV32I immediate formatter selected by imm_src.
module immediate_generator
    import rv32_pkg::*;
(
    input  logic [XLEN_W-1:0] instr,
    input  imm_src_t          imm_src,
    output logic [XLEN_W-1:0] imm_c
);

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm_c = '0;
        case (imm_src)
            IMM_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm_c = {instr[31:12], 12'b0};
            IMM_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// ID stage controller: opcode classification, immediate formatting, skid-buffered ID/EX handoff, stall counter.
// Optional build macro: DECODE_ILLEGAL_CHECK_EN flags unknown opcodes as illegal.
module decode_stage_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [2:0]       id_imm_src,
    output logic [XLEN-1:0]  id_imm,
    output logic             id_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    imm_src_t          imm_src_c;
    logic              zero_imm_c;
    logic              illegal_c;
    logic [XLEN_W-1:0] gen_imm_c;
    id_entry_t         in_entry_c;
    id_entry_t         out_entry;
    logic              out_valid;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // R-type reports the I format but carries no immediate.
    always_comb begin
        imm_src_c  = IMM_I;
        zero_imm_c = 1'b0;
        illegal_c  = 1'b0;
        case (if_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: imm_src_c = IMM_I;
            OPC_STORE:            imm_src_c = IMM_S;
            OPC_BRANCH:           imm_src_c = IMM_B;
            OPC_LUI, OPC_AUIPC:   imm_src_c = IMM_U;
            OPC_JAL:              imm_src_c = IMM_J;
            OPC_OP:               zero_imm_c = 1'b1;
`ifdef DECODE_ILLEGAL_CHECK_EN
            default: begin
                illegal_c  = 1'b1;
                zero_imm_c = 1'b1;
            end
`else
            default:              imm_src_c = IMM_I;
`endif
        endcase
    end

    immediate_generator u_imm_gen (
        .instr   (if_instr),
        .imm_src (imm_src_c),
        .imm_c   (gen_imm_c)
    );

    always_comb begin
        in_entry_c         = '0;
        in_entry_c.instr   = if_instr;
        in_entry_c.pc      = if_pc;
        in_entry_c.imm_src = imm_src_c;
        in_entry_c.imm     = zero_imm_c ? '0 : gen_imm_c;
        in_entry_c.illegal = illegal_c;
    end

    id_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_entry  (in_entry_c),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (id_ready),
        .out_entry (out_entry)
    );

    // Saturating back-pressure counter; flush does not touch it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !id_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_valid   = out_valid;
    assign id_instr   = out_entry.instr;
    assign id_pc      = out_entry.pc;
    assign id_imm_src = out_entry.imm_src;
    assign id_imm     = out_entry.imm;
    assign id_illegal = out_entry.illegal;
    assign stall_cnt  = stall_cnt_q;

endmodule
